// File: rtl/path_pkg.sv
// Shared types and defaults for the path replay block: direction codes,
// player state encoding and default buffer geometry.
package path_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int DEFAULT_DEPTH = 256;
  localparam int DEFAULT_AW    = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    PLAY,
    DONE
  } player_state_t;

endpackage

// File: rtl/path_buf.sv
// Local move buffer: DEPTH x 2-bit register array with one synchronous
// write port and one combinational read port. Contents are not reset.
module path_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/path_player.sv
// Drains the direction stack into a local buffer, then replays the moves in
// forward order on a valid/ready stream. Optional PATH_PLAYER_REPEAT_EN adds
// a repeat_req input that replays the last captured path without draining.
module path_player
  import path_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        stack_pop,
  input  logic [1:0]  stack_data,
  input  logic        stack_empty,
  output logic [1:0]  move,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [AW:0] length,
  output logic        busy,
  output logic        done,
  output logic        overflow
`ifdef PATH_PLAYER_REPEAT_EN
  ,
  input  logic        repeat_req
`endif
);

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] IDX_ONE   = 1;

  player_state_t state, state_nxt;
  logic [AW:0]   wr_cnt;
  logic [AW:0]   in_flight;
  logic [AW-1:0] rd_idx;
  logic          pop_d;
  logic          drain_exit;
  logic [1:0]    rd_data;

  // Count the pop still awaiting capture so the buffer can never be over-popped.
  assign in_flight = wr_cnt + {{AW{1'b0}}, pop_d};

  path_buf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clk  (clk),
    .we   ((state == DRAIN) && pop_d),
    .waddr(wr_cnt[AW-1:0]),
    .wdata(stack_data),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    stack_pop  = 1'b0;
    move_valid = 1'b0;
    drain_exit = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRAIN;
        end
`ifdef PATH_PLAYER_REPEAT_EN
        else if (repeat_req && (length != '0)) begin
          state_nxt = PLAY;
        end
`endif
      end
      DRAIN: begin
        stack_pop = !stack_empty && (in_flight != DEPTH_CNT);
        if (!stack_pop && !pop_d) begin
          drain_exit = 1'b1;
          state_nxt  = (wr_cnt != '0) ? PLAY : DONE;
        end
      end
      PLAY: begin
        move_valid = 1'b1;
        if (move_ready && (rd_idx == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Replay walks down from the newest capture, since the stack pops last move first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt   <= '0;
      pop_d    <= 1'b0;
      length   <= '0;
      rd_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wr_cnt   <= '0;
            pop_d    <= 1'b0;
            overflow <= 1'b0;
          end
`ifdef PATH_PLAYER_REPEAT_EN
          else if (repeat_req && (length != '0)) begin
            rd_idx <= AW'(length - CNT_ONE);
          end
`endif
        end
        DRAIN: begin
          pop_d <= stack_pop;
          if (pop_d) begin
            wr_cnt <= wr_cnt + CNT_ONE;
          end
          if (drain_exit) begin
            length <= wr_cnt;
            rd_idx <= (wr_cnt != '0) ? AW'(wr_cnt - CNT_ONE) : '0;
            if (!stack_empty) begin
              overflow <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (move_ready && (rd_idx != '0)) begin
            rd_idx <= rd_idx - IDX_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign move = move_valid ? rd_data : DIR_UP;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_path_player.sv
// Bench for path_player: a queue-based stack model feeds the DUT and a
// per-cycle reference of the drain/replay schedule checks every output.
module tb_path_player;
  import path_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stack_pop;
  logic [1:0]    stack_data;
  logic          stack_empty;
  logic [1:0]    move;
  logic          move_valid;
  logic          move_ready;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef PATH_PLAYER_REPEAT_EN
  logic          repeat_req;
`endif

  logic [1:0] stk[$];
  logic [1:0] plan[$];
  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  path_player #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stack_pop  (stack_pop),
    .stack_data (stack_data),
    .stack_empty(stack_empty),
    .move       (move),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
`ifdef PATH_PLAYER_REPEAT_EN
    ,
    .repeat_req (repeat_req)
`endif
  );

  // Stack model: popped value appears the cycle after the pop edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stk.delete();
      stack_data  <= 2'd0;
      stack_empty <= 1'b1;
    end else begin
      if (stack_pop && (stk.size() > 0)) begin
        stack_data <= stk[$];
        stk.pop_back();
      end
      stack_empty <= (stk.size() == 0);
    end
  end

  task automatic checkOutput(input string tag, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic randomPlan(input int n);
    plan.delete();
    for (int i = 0; i < n; i++) plan.push_back(2'($urandom_range(3, 0)));
  endtask

  // Loads plan into the stack, pulses start, then checks every cycle against
  // the expected schedule: pops in cycles 0..P-1, moves from cycle P+2.
  task automatic applyStimulus(input int mode);
    int m;
    int p;
    int hs;
    int doneRel;
    bit finished;
    bit expValid;
    logic [1:0] expMoves[$];
    m = plan.size();
    p = (m > DEPTH) ? DEPTH : m;
    hs = 0;
    finished = 1'b0;
    stk.delete();
    for (int i = 0; i < m; i++) stk.push_back(plan[i]);
    for (int i = m - p; i < m; i++) expMoves.push_back(plan[i]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneRel = (p == 0) ? 1 : 1000000;
    for (int rel = 0; rel < 200 && !finished; rel++) begin
      case (mode)
        0:       move_ready = 1'b1;
        1:       move_ready = ((rel % 3) == 0);
        default: move_ready = 1'($urandom_range(1, 0));
      endcase
      if (rel == doneRel + 1) begin
        checkOutput("done_after", done, 0);
        checkOutput("busy_after", busy, 0);
        checkOutput("valid_after", move_valid, 0);
        checkOutput("length", length, p);
        checkOutput("overflow", overflow, (m > DEPTH) ? 1 : 0);
        checkOutput("stack_left", stk.size(), m - p);
        finished = 1'b1;
      end else begin
        expValid = (p > 0) && (rel >= p + 2) && (hs < p);
        checkOutput("stack_pop", stack_pop, (rel < p) ? 1 : 0);
        checkOutput("move_valid", move_valid, expValid);
        checkOutput("done", done, (rel == doneRel) ? 1 : 0);
        checkOutput("busy", busy, 1);
        if (expValid) begin
          checkOutput("move", move, expMoves[hs]);
          if (move_ready) begin
            hs++;
            if (hs == p) doneRel = rel + 1;
          end
        end
        @(negedge clk);
      end
    end
    if (!finished) checkOutput("timeout", 0, 1);
    move_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    move_ready = 1'b0;
`ifdef PATH_PLAYER_REPEAT_EN
    repeat_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_pop", stack_pop, 0);
    checkOutput("rst_move", move, 0);
    checkOutput("rst_valid", move_valid, 0);
    checkOutput("rst_length", length, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Three pushed moves replayed in push order.
    plan.delete();
    plan.push_back(DIR_RIGHT);
    plan.push_back(DIR_DOWN);
    plan.push_back(DIR_LEFT);
    applyStimulus(0);

    // Empty stack: straight to DONE.
    plan.delete();
    applyStimulus(0);

    // Four entries with stalling ready.
    randomPlan(4);
    applyStimulus(1);

    // Six entries into a four-deep buffer.
    randomPlan(6);
    applyStimulus(0);

    // Reset in the middle of a drain.
    randomPlan(4);
    stk.delete();
    for (int i = 0; i < 4; i++) stk.push_back(plan[i]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_pop", stack_pop, 0);
    checkOutput("mid_rst_move", move, 0);
    checkOutput("mid_rst_valid", move_valid, 0);
    checkOutput("mid_rst_length", length, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    randomPlan(3);
    applyStimulus(0);

    for (int t = 0; t < 20; t++) begin
      randomPlan($urandom_range(7, 0));
      applyStimulus($urandom_range(2, 0));
    end

`ifdef PATH_PLAYER_REPEAT_EN
    plan.delete();
    plan.push_back(DIR_UP);
    plan.push_back(DIR_RIGHT);
    applyStimulus(0);
    @(negedge clk);
    repeat_req = 1'b1;
    @(negedge clk);
    repeat_req = 1'b0;
    move_ready = 1'b1;
    checkOutput("rep_valid0", move_valid, 1);
    checkOutput("rep_move0", move, DIR_UP);
    checkOutput("rep_pop0", stack_pop, 0);
    @(negedge clk);
    checkOutput("rep_valid1", move_valid, 1);
    checkOutput("rep_move1", move, DIR_RIGHT);
    checkOutput("rep_pop1", stack_pop, 0);
    @(negedge clk);
    move_ready = 1'b0;
    checkOutput("rep_done", done, 1);
    checkOutput("rep_valid2", move_valid, 0);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
